// File: rtl/pipe_ctrl_pkg.sv
// Shared types and latch indices for the pipeline motion controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} pipe_state_t;

  typedef enum logic [1:0] {NONE, MEMWAIT, LOADUSE, IMISS} stall_cause_t;

  localparam int unsigned L_IFID  = 0;
  localparam int unsigned L_IDEX  = 1;
  localparam int unsigned L_EXMEM = 2;
  localparam int unsigned L_MEMWB = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_motion_ctrl.sv
// Central pipeline motion controller: per-latch enable/flush, valid tracking,
// stall arbitration, redirect squash and halt drain.
module pipe_motion_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE    = 4,
  parameter int unsigned MEM_LATCH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmem_req,
  input  logic              load_use,
  input  logic              redirect,
  input  logic              halt_id,
  output logic              pc_en,
  output logic [NSTAGE-1:0] lat_en,
  output logic [NSTAGE-1:0] lat_flush,
  output logic [NSTAGE-1:0] lat_valid,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned BubbleLatch = MEM_LATCH + 1;

  pipe_state_t       state_q, state_d;
  stall_cause_t      cause;
  logic [NSTAGE-1:0] lat_valid_q, lat_valid_d;
  logic [NSTAGE-1:0] halt_vec_q, halt_vec_d;
  logic              halt_q, halt_d;
  logic              pc_en_prev_q;
  logic              pc_en_int;
  logic              redirect_ok;
  logic              stall_inc;

  // Stall cause arbitration and per-latch motion.
  always_comb begin
    cause = NONE;
    if (lat_valid_q[MEM_LATCH] && dmem_req && !dhit) begin
      cause = MEMWAIT;
    end else if (load_use && lat_valid_q[L_IFID]) begin
      cause = LOADUSE;
    end else if (!ihit) begin
      cause = IMISS;
    end

    lat_en      = '1;
    lat_flush   = '0;
    pc_en_int   = 1'b1;
    redirect_ok = 1'b0;
    state_d     = state_q;

    case (cause)
      MEMWAIT: begin
        pc_en_int = 1'b0;
        for (int i = 0; i <= int'(MEM_LATCH); i++) begin
          lat_en[i] = 1'b0;
        end
        lat_flush[BubbleLatch] = 1'b1;
      end
      LOADUSE: begin
        pc_en_int         = 1'b0;
        lat_en[L_IFID]    = 1'b0;
        lat_flush[L_IDEX] = 1'b1;
      end
      IMISS: begin
        pc_en_int         = 1'b0;
        lat_flush[L_IFID] = 1'b1;
      end
      default: ;
    endcase

    unique case (state_q)
      RUN: begin
        // Accepting HALT also squashes the fetch behind it; halt beats redirect.
        if (halt_id && lat_valid_q[L_IFID] && lat_en[L_IDEX] && !lat_flush[L_IDEX]) begin
          state_d           = DRAIN;
          pc_en_int         = 1'b0;
          lat_flush[L_IFID] = 1'b1;
        end else if (redirect && (cause != MEMWAIT) && (cause != LOADUSE)) begin
          redirect_ok       = 1'b1;
          pc_en_int         = 1'b1;
          lat_flush[L_IFID] = 1'b1;
        end
      end
      DRAIN: begin
        pc_en_int         = 1'b0;
        lat_flush[L_IFID] = 1'b1;
        if (halt_vec_q[NSTAGE-1] && lat_valid_q[NSTAGE-1]) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        pc_en_int = 1'b0;
        lat_en    = '0;
        lat_flush = '0;
      end
      default: state_d = RUN;
    endcase
  end

  // Valid and halt-marker chains; flush clears, a disabled latch holds.
  always_comb begin
    lat_valid_d = lat_valid_q;
    halt_vec_d  = halt_vec_q;
    if (lat_flush[L_IFID]) begin
      lat_valid_d[L_IFID] = 1'b0;
    end else if (lat_en[L_IFID]) begin
      lat_valid_d[L_IFID] = ihit && pc_en_prev_q && (state_q == RUN);
    end
    halt_vec_d[L_IFID] = 1'b0;
    for (int i = 1; i < int'(NSTAGE); i++) begin
      if (lat_flush[i]) begin
        lat_valid_d[i] = 1'b0;
        halt_vec_d[i]  = 1'b0;
      end else if (lat_en[i]) begin
        lat_valid_d[i] = lat_valid_q[i-1];
        halt_vec_d[i]  = (i == 1) ? (halt_id && lat_valid_q[L_IFID]) : halt_vec_q[i-1];
      end
    end
    halt_d = halt_q || (halt_vec_d[NSTAGE-1] && lat_valid_d[NSTAGE-1]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      lat_valid_q  <= '0;
      halt_vec_q   <= '0;
      halt_q       <= 1'b0;
      pc_en_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_valid_q  <= lat_valid_d;
      halt_vec_q   <= halt_vec_d;
      halt_q       <= halt_d;
      pc_en_prev_q <= pc_en;
    end
  end

  assign stall_inc = (state_q == RUN) && (cause != NONE);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .clr  (1'b0),
    .q    (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (redirect_ok),
    .clr  (1'b0),
    .q    (flush_cnt)
  );

  assign pc_en     = pc_en_int & nRST;
  assign lat_valid = lat_valid_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_pipe_motion_ctrl.sv
// Directed bench for pipe_motion_ctrl; a narrow-counter instance exercises saturation.
module tb_pipe_motion_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, dmem_req, load_use, redirect, halt_id;
  logic        pc_en;
  logic [3:0]  lat_en, lat_flush, lat_valid;
  logic        halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        rst_s, ihit_s;
  logic        pc_en_s, halt_s;
  logic [3:0]  lat_en_s, lat_flush_s, lat_valid_s;
  logic [3:0]  stall_cnt_s, flush_cnt_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  pipe_motion_ctrl #(
    .NSTAGE    (4),
    .MEM_LATCH (2),
    .CNT_W     (16)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .dhit      (dhit),
    .dmem_req  (dmem_req),
    .load_use  (load_use),
    .redirect  (redirect),
    .halt_id   (halt_id),
    .pc_en     (pc_en),
    .lat_en    (lat_en),
    .lat_flush (lat_flush),
    .lat_valid (lat_valid),
    .halt      (halt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  pipe_motion_ctrl #(
    .NSTAGE    (4),
    .MEM_LATCH (2),
    .CNT_W     (4)
  ) dut_sat (
    .CLK       (CLK),
    .nRST      (rst_s),
    .ihit      (ihit_s),
    .dhit      (1'b0),
    .dmem_req  (1'b0),
    .load_use  (1'b0),
    .redirect  (1'b0),
    .halt_id   (1'b0),
    .pc_en     (pc_en_s),
    .lat_en    (lat_en_s),
    .lat_flush (lat_flush_s),
    .lat_valid (lat_valid_s),
    .halt      (halt_s),
    .stall_cnt (stall_cnt_s),
    .flush_cnt (flush_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] fill_exp [5];
    fill_exp[0] = 4'b0000;
    fill_exp[1] = 4'b0001;
    fill_exp[2] = 4'b0011;
    fill_exp[3] = 4'b0111;
    fill_exp[4] = 4'b1111;

    nRST = 1'b0; rst_s = 1'b0; ihit_s = 1'b0;
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0;
    load_use = 1'b0; redirect = 1'b0; halt_id = 1'b0;
    #2;
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    chk("rst_valid", 32'(lat_valid), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    tick();
    tick();

    // 1: fill with no hazards
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("fill_pc_en0", 32'(pc_en), 32'h1);
    chk("fill_lat_en", 32'(lat_en), 32'hF);
    chk("fill_lat_flush", 32'(lat_flush), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fill_valid", 32'(lat_valid), 32'(fill_exp[k]));
      chk("fill_pc_en", 32'(pc_en), 32'h1);
    end
    tick();
    chk("fill_valid_hold", 32'(lat_valid), 32'hF);
    chk("fill_stall_cnt", 32'(stall_cnt), 32'h0);

    // 2: memory wait for three cycles
    dmem_req = 1'b1; dhit = 1'b0;
    #1;
    chk("mw_pc_en", 32'(pc_en), 32'h0);
    chk("mw_lat_en", 32'(lat_en), 32'h8);
    chk("mw_lat_flush", 32'(lat_flush), 32'h8);
    tick();
    tick();
    tick();
    chk("mw_valid", 32'(lat_valid), 32'h7);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'h3);
    dmem_req = 1'b0; dhit = 1'b1;
    #1;
    chk("mw_release_pc_en", 32'(pc_en), 32'h1);
    chk("mw_release_lat_en", 32'(lat_en), 32'hF);
    tick();
    chk("mw_release_valid", 32'(lat_valid), 32'hE);
    for (int k = 0; k < 4; k++) tick();
    chk("mw_refill_valid", 32'(lat_valid), 32'hF);
    chk("mw_stall_cnt_hold", 32'(stall_cnt), 32'h3);

    // 3: one load-use bubble
    load_use = 1'b1;
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'h0);
    chk("lu_lat_en", 32'(lat_en), 32'hE);
    chk("lu_lat_flush", 32'(lat_flush), 32'h2);
    tick();
    load_use = 1'b0;
    chk("lu_valid", 32'(lat_valid), 32'hD);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h4);
    #1;
    chk("lu_resume_pc_en", 32'(pc_en), 32'h1);
    tick();
    chk("lu_valid2", 32'(lat_valid), 32'hA);
    for (int k = 0; k < 4; k++) tick();
    chk("lu_refill_valid", 32'(lat_valid), 32'hF);

    // 4: redirect under memory wait is ignored, then honoured
    dmem_req = 1'b1; dhit = 1'b0; redirect = 1'b1;
    #1;
    chk("rd_mw_flush", 32'(lat_flush), 32'h8);
    chk("rd_mw_pc_en", 32'(pc_en), 32'h0);
    tick();
    chk("rd_mw_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("rd_mw_stall_cnt", 32'(stall_cnt), 32'h5);
    dmem_req = 1'b0; dhit = 1'b1;
    #1;
    chk("rd_flush", 32'(lat_flush), 32'h1);
    chk("rd_pc_en", 32'(pc_en), 32'h1);
    tick();
    redirect = 1'b0;
    chk("rd_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("rd_valid", 32'(lat_valid), 32'hE);
    for (int k = 0; k < 4; k++) tick();
    chk("rd_refill_valid", 32'(lat_valid), 32'hF);

    // 5: halt drain
    halt_id = 1'b1;
    #1;
    chk("hl_accept_pc_en", 32'(pc_en), 32'h0);
    chk("hl_accept_flush", 32'(lat_flush), 32'h1);
    tick();
    halt_id = 1'b0;
    chk("hl_halt_c1", 32'(halt), 32'h0);
    chk("hl_valid_c1", 32'(lat_valid), 32'hE);
    #1;
    chk("hl_drain_pc_en", 32'(pc_en), 32'h0);
    chk("hl_drain_flush", 32'(lat_flush), 32'h1);
    tick();
    chk("hl_halt_c2", 32'(halt), 32'h0);
    tick();
    chk("hl_halt_c3", 32'(halt), 32'h1);
    tick();
    redirect = 1'b1; ihit = 1'b0;
    #1;
    chk("hl_halted_pc_en", 32'(pc_en), 32'h0);
    chk("hl_halted_lat_en", 32'(lat_en), 32'h0);
    chk("hl_halted_flush", 32'(lat_flush), 32'h0);
    tick();
    redirect = 1'b0; ihit = 1'b1;
    tick();
    chk("hl_sticky", 32'(halt), 32'h1);
    chk("hl_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("hl_stall_cnt", 32'(stall_cnt), 32'h5);
    chk("hl_valid_frozen", 32'(lat_valid), 32'h0);

    // 6: asynchronous reset in the middle of a memory wait
    nRST = 1'b0;
    tick();
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("ar_fill_valid", 32'(lat_valid), 32'h7);
    dmem_req = 1'b1; dhit = 1'b0;
    tick();
    tick();
    chk("ar_pre_stall_cnt", 32'(stall_cnt), 32'h2);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_valid", 32'(lat_valid), 32'h0);
    chk("ar_halt", 32'(halt), 32'h0);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("ar_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("ar_pc_en", 32'(pc_en), 32'h0);
    dmem_req = 1'b0; dhit = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("ar_post_stall_cnt", 32'(stall_cnt), 32'h0);

    // Saturation on the 4-bit instance: continuous fetch miss
    chk("sat_start", 32'(stall_cnt_s), 32'h0);
    @(negedge CLK);
    rst_s = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    chk("sat_cnt14", 32'(stall_cnt_s), 32'hE);
    tick();
    chk("sat_cnt15", 32'(stall_cnt_s), 32'hF);
    for (int k = 0; k < 3; k++) tick();
    chk("sat_hold", 32'(stall_cnt_s), 32'hF);
    chk("sat_flush_cnt", 32'(flush_cnt_s), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
